// File: rtl/arb_rr4.sv
// rtl/arb_rr4.sv - four-requester round-robin arbiter with registered one-hot grant
//
// Purpose
//    Grants one of four requesters access to a shared resource. The search
//    order starts at a rotating pointer, so the most recent winner is always
//    searched last on the next arbitration. A holder keeps the grant for as
//    long as it requests it. When it releases, the next winner is granted on
//    the same edge, so there is no idle cycle between holders.
//
// Optional feature
//    ARB_TIMEOUT_EN : when defined, an 8-bit hold counter limits each holder
//                     to HOLD_MAX consecutive grant cycles. At the limit the
//                     holder is treated as if it had dropped its request. If
//                     nobody else is waiting, it is re-granted at once with a
//                     fresh count. When undefined, no counter is built and
//                     HOLD_MAX has no effect.
//
// Parameters
//    HOLD_MAX  : maximum consecutive grant cycles per holder (2..255)
//
// Ports
//    clk       in   1  single clock, rising edge
//    rst_n     in   1  asynchronous active-low reset
//    en        in   1  arbiter enable; low releases any grant
//    req       in   4  request lines, one per requester
//    gnt       out  4  one-hot grant, all zero when gnt_vld is low
//    gnt_idx   out  2  binary index of the current or last holder
//    gnt_vld   out  1  high while a grant is held

module arb_rr4 #(
   parameter int HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_vld
);

   if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_range
      $error("arb_rr4: HOLD_MAX must lie in 2..255");
   end

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] ptr_q,   ptr_d;
   logic [1:0] idx_q,   idx_d;
   logic       vld_q,   vld_d;
   logic [3:0] gnt_q,   gnt_d;

   // {found, index} of the first set bit of r, scanning p, p+1, p+2, p+3 mod 4
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] cand;
      res = 3'b000;
      for (int k = 0; k < 4; k++) begin
         cand = p + 2'(k);
         if (!res[2] && r[cand]) begin
            res = {1'b1, cand};
         end
      end
      return res;
   endfunction

   function automatic logic [3:0] dec2to4(input logic [1:0] i);
      logic [3:0] d;
      d = 4'b0000;
      d[i] = 1'b1;
      return d;
   endfunction

   logic [2:0] pick_all;
   logic [2:0] pick_oth;

   // pick_all arbitrates from idle. pick_oth arbitrates a hand-over: it
   // excludes the current holder. The pointer already sits at holder+1,
   // so the holder would be searched last in any case.
   assign pick_all = rr_pick(req, ptr_q);
   assign pick_oth = rr_pick(req & ~dec2to4(idx_q), ptr_q);

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

   logic [7:0] cnt_q, cnt_d;
   logic       timeout;

   // The counter holds the number of grant cycles already served by the
   // current holder, including the cycle in progress.
   assign timeout = (cnt_q == HOLD_LIM);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= 2'd0;
         idx_q   <= 2'd0;
         vld_q   <= 1'b0;
         gnt_q   <= 4'b0000;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         gnt_q   <= gnt_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif

      if (!en) begin
         // Disable releases the grant. The pointer and the last index are
         // kept, so arbitration resumes in the same order.
         state_d = ST_IDLE;
         vld_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_d   = 8'd0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_all[2]) begin
                  state_d = ST_GRANT;
                  idx_d   = pick_all[1:0];
                  ptr_d   = pick_all[1:0] + 2'd1;
                  vld_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
                  cnt_d   = 8'd1;
`endif
               end
            end

            ST_GRANT: begin
`ifdef ARB_TIMEOUT_EN
               if (req[idx_q] && !timeout) begin
                  cnt_d = cnt_q + 8'd1;
               end else if (pick_oth[2]) begin
                  idx_d = pick_oth[1:0];
                  ptr_d = pick_oth[1:0] + 2'd1;
                  cnt_d = 8'd1;
               end else if (req[idx_q]) begin
                  // The holder timed out, but no one else is waiting, so it is
                  // re-granted with a fresh count and gnt_vld does not drop.
                  ptr_d = idx_q + 2'd1;
                  cnt_d = 8'd1;
               end else begin
                  state_d = ST_IDLE;
                  vld_d   = 1'b0;
                  cnt_d   = 8'd0;
               end
`else
               if (req[idx_q]) begin
                  state_d = ST_GRANT;
               end else if (pick_oth[2]) begin
                  idx_d = pick_oth[1:0];
                  ptr_d = pick_oth[1:0] + 2'd1;
               end else begin
                  state_d = ST_IDLE;
                  vld_d   = 1'b0;
               end
`endif
            end

            default: begin
               state_d = ST_IDLE;
               vld_d   = 1'b0;
            end
         endcase
      end

      gnt_d = vld_d ? dec2to4(idx_d) : 4'b0000;
   end

   assign gnt     = gnt_q;
   assign gnt_idx = idx_q;
   assign gnt_vld = vld_q;

endmodule

// File: tb/tb_arb_rr4.sv
// tb/tb_arb_rr4.sv - scoreboard testbench for arb_rr4

module tb_arb_rr4;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;

   arb_rr4 #(.HOLD_MAX(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic [6:0] word;   // {gnt, gnt_idx, gnt_vld}
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string nm, input logic [6:0] got, input logic [6:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got {gnt,idx,vld}=%b required %b", nm, got, exp);
   endtask

   function automatic logic [6:0] mk(input logic [1:0] idx, input logic vld);
      logic [3:0] g;
      g = 4'b0000;
      if (vld) g[idx] = 1'b1;
      return {g, idx, vld};
   endfunction

   // Drives one cycle of stimulus and queues the outputs expected after the next rising edge.
   task automatic cyc(input logic e, input logic [3:0] r, input logic [1:0] ei, input logic ev,
                      input string nm);
      exp_t x;
      @(negedge clk);
      en  = e;
      req = r;
      x.nm   = nm;
      x.word = mk(ei, ev);
      exp_q.push_back(x);
   endtask

   // Monitor: compares one queued expectation against the registered outputs after every edge.
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         check(x.nm, {gnt, gnt_idx, gnt_vld}, x.word);
      end
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 4'b0000;
      #12;
      check("reset_state", {gnt, gnt_idx, gnt_vld}, 7'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic grant, no preemption, hand-over, and release to idle
      cyc(1'b1, 4'b0101, 2'd0, 1'b1, "first_grant0");
      cyc(1'b1, 4'b0101, 2'd0, 1'b1, "hold0_no_preempt");
      cyc(1'b1, 4'b0100, 2'd2, 1'b1, "handover_to2");
      cyc(1'b1, 4'b0000, 2'd2, 1'b0, "release_to_idle");
      cyc(1'b1, 4'b0000, 2'd2, 1'b0, "idle_stays_idle");

      // Rotation with all requesting (ptr=3): 3,0,1,2,3,0
      cyc(1'b1, 4'b1111, 2'd3, 1'b1, "rr_all_3");
      cyc(1'b1, 4'b0111, 2'd0, 1'b1, "rr_0");
      cyc(1'b1, 4'b1110, 2'd1, 1'b1, "rr_1");
      cyc(1'b1, 4'b1101, 2'd2, 1'b1, "rr_2");
      cyc(1'b1, 4'b1011, 2'd3, 1'b1, "rr_3");
      cyc(1'b1, 4'b0111, 2'd0, 1'b1, "rr_wrap_0");

      // Enable drop during a grant to 3, then resume with ptr=0
      cyc(1'b1, 4'b1000, 2'd3, 1'b1, "grant3");
      cyc(1'b0, 4'b1000, 2'd3, 1'b0, "en_low_release");
      cyc(1'b1, 4'b1001, 2'd0, 1'b1, "en_high_grant0");
      cyc(1'b0, 4'b1001, 2'd0, 1'b0, "en_low_again");

      // A holder that was released and re-requests is searched last
      cyc(1'b1, 4'b0011, 2'd1, 1'b1, "ptr1_grant1");
      cyc(1'b1, 4'b0001, 2'd0, 1'b1, "drop1_grant0");
      cyc(1'b1, 4'b0010, 2'd1, 1'b1, "drop0_grant1");
      cyc(1'b1, 4'b0011, 2'd1, 1'b1, "hold1_vs_reasserted0");

      // Asynchronous reset in the middle of a cycle while a grant is held
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_clears", {gnt, gnt_idx, gnt_vld}, 7'b0);
      @(negedge clk);
      rst_n = 1'b1;
      // After reset ptr=0, so 0110 picks 1 (a surviving ptr=2 would pick 2)
      cyc(1'b1, 4'b0110, 2'd1, 1'b1, "post_reset_ptr0");
      cyc(1'b1, 4'b0000, 2'd1, 1'b0, "post_reset_idle");

`ifdef ARB_TIMEOUT_EN
      // ptr=2, so 0011 picks 0 first; the grant then alternates every 8 cycles
      for (int k = 0; k < 24; k++) begin
         cyc(1'b1, 4'b0011, ((k / 8) % 2 == 0) ? 2'd0 : 2'd1, 1'b1, "timeout_alternate");
      end
      for (int k = 0; k < 20; k++) begin
         cyc(1'b1, 4'b0001, 2'd0, 1'b1, "timeout_regrant_same");
      end
`else
      // Without timeout the hold is unbounded
      for (int k = 0; k < 20; k++) begin
         cyc(1'b1, 4'b0011, 2'd0, 1'b1, "unbounded_hold0");
      end
`endif

      @(posedge clk);
      #3;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL queue_drained: got %0d pending required 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/arb_rr4.md
ARB_RR4 -- requirements
Module: arb_rr4

Interface
REQ-001 Parameter: HOLD_MAX, 8, maximum consecutive grant cycles per holder when ARB_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 Port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Port: EN  input  1  arbiter enable; low forces release of any grant.
REQ-005 Port: REQ  input  4  request lines; REQ[i] high means requester i wants the shared resource.
REQ-006 Port: GNT  output  4  one-hot grant, 2-to-4 decode of GNT_IDX gated by GNT_VLD.
REQ-007 Port: GNT_IDX  output  2  binary index of the current holder.
REQ-008 Port: GNT_VLD  output  1  high while a grant is held.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one holder).
REQ-010 GNT, GNT_IDX and GNT_VLD SHALL be registered outputs; GNT SHALL equal 4'b0000 whenever GNT_VLD is low and exactly one-hot otherwise.
REQ-011 A round-robin pointer PTR (2 bits) SHALL define search order PTR, PTR+1, PTR+2, PTR+3 modulo 4; winner is the first requesting index in that order.
REQ-012 IDLE -> GRANT: when EN=1 and REQ!=0 at an edge, the winner SHALL appear on GNT/GNT_IDX with GNT_VLD=1 at that same edge (one-cycle latency from sampled request).
REQ-013 On every new grant PTR SHALL load winner+1 modulo 4 (3 wraps to 0).
REQ-014 In GRANT, holder keeps the grant while REQ[GNT_IDX]=1 and EN=1; other requests SHALL NOT preempt it.
REQ-015 In GRANT, when REQ[GNT_IDX]=0 is sampled and EN=1: if any other REQ bit is high the winner (per REQ-011, updated PTR) SHALL be granted at that edge with no idle cycle; otherwise FSM SHALL enter IDLE with GNT_VLD=0.
REQ-016 EN=0 sampled in any state SHALL move FSM to IDLE, clear GNT_VLD and GNT, and leave PTR unchanged.
REQ-017 Simultaneous release by holder and new requests in the same cycle SHALL follow REQ-015; a released holder that re-asserts REQ is arbitrated normally and is last in order.
REQ-018 REQ=4'b0000 in IDLE SHALL keep FSM in IDLE with all outputs unchanged.
REQ-019 GNT_IDX SHALL retain its last value while GNT_VLD=0.

Reset
REQ-020 RST_N low SHALL immediately (without CLK) force FSM=IDLE, GNT=0, GNT_IDX=0, GNT_VLD=0, PTR=0, hold counter=0.
REQ-021 After RST_N deasserts, the first arbitration SHALL occur on the first rising CLK edge with RST_N high.
REQ-022 Reset asserted mid-grant SHALL drop the grant immediately; no state survives.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL count GRANT cycles of the current holder; after HOLD_MAX consecutive GNT_VLD cycles the grant SHALL be forcibly released and re-arbitrated per REQ-015 as if the holder dropped REQ.
REQ-024 With ARB_TIMEOUT_EN defined and no other request pending at timeout, the same holder SHALL be re-granted with counter restarted and GNT_VLD remaining high.
REQ-025 Macro ARB_TIMEOUT_EN undefined: no counter SHALL be built, hold is unbounded, HOLD_MAX is ignored.

Verification
REQ-026 Reset, then REQ=4'b0101 with EN=1 at edge 1 -> GNT=4'b0001, GNT_IDX=0, GNT_VLD=1 after edge 1; PTR=1.
REQ-027 Holder 0 drops REQ while REQ[2]=1 -> next edge GNT=4'b0100, no GNT_VLD gap; drop REQ[2] with REQ=0 -> next edge GNT_VLD=0, GNT=0.
REQ-028 All four REQ held, each holder drops after 1 cycle and re-asserts -> grant sequence 0,1,2,3,0 (wrap).
REQ-029 EN driven low during grant to 3 -> next edge GNT=0, GNT_VLD=0; EN high with REQ=4'b1001 -> grant 0 (PTR=0 after wrap).
REQ-030 ARB_TIMEOUT_EN, HOLD_MAX=8, REQ=4'b0011 held constantly -> GNT alternates 0 and 1 every 8 cycles; REQ=4'b0001 only -> GNT_VLD continuously 1, GNT=4'b0001.
REQ-031 RST_N pulsed low mid-grant between clock edges -> outputs zero asynchronously before next CLK edge.
